ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- iload  out  32  instruction read data
- iwait  out  1  instruction not done
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- dload  out  32  data read data
- dwait  out  1  data not done
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t from cpu_types_pkg: FREE, BUSY, ACCESS, ERROR
- ramerr  out  1  sticky failed-transaction flag
REQ-002 SHALL have parameters (name, default, meaning): MAX_RETRY, 3, ERROR responses tolerated before a transaction is abandoned; DSTREAK, 2, consecutive data grants allowed while iREN is pending.

Function
REQ-003 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, RETRY.
REQ-004 IDLE: SHALL grant data when (dREN|dWEN) and not (streak==DSTREAK and iREN); SHALL grant instruction when iREN and not granting data.
REQ-005 On grant, SHALL latch address, store data and op (dWEN overrides dREN: write only) into registers; SHALL enter SERVE_I or SERVE_D next cycle.
REQ-006 Latency: request sampled in IDLE at edge N; ramREN/ramWEN asserted from cycle N+1.
REQ-007 In SERVE_x, ramaddr/ramstore/ramREN/ramWEN SHALL come only from latched registers and stay stable until completion.
REQ-008 Completion: in SERVE_x with ramstate==ACCESS, the served wait SHALL be 0 combinationally that cycle, with xload=ramload (reads); next state IDLE.
REQ-009 iwait/dwait SHALL be 1 in every other cycle; iload/dload SHALL be 0 when not completing.
REQ-010 ramstate FREE/BUSY in SERVE_x: SHALL hold state and outputs.
REQ-011 ramstate ERROR in SERVE_x: SHALL increment a retry count and enter RETRY; in RETRY, ramREN=ramWEN=0 for exactly one cycle, then return to the same SERVE_x with unchanged registers.
REQ-012 On the ERROR that makes retry count exceed MAX_RETRY, SHALL complete (wait=0, load=32'hBAD1BAD1), set ramerr, and go to IDLE; ramerr SHALL clear only on reset.
REQ-013 Retry count SHALL clear on every grant.
REQ-014 Streak counter (2 bits, saturating at DSTREAK): increments on a data grant while iREN=1; clears on an instruction grant or any grant with iREN=0.
REQ-015 IDLE SHALL drive ramREN=ramWEN=0, ramaddr=ramstore=0, so there is a one-cycle turnaround between transactions.
REQ-016 A request deasserted mid-transaction SHALL NOT abort it; the RAM access completes and the wait/load pulse is still produced.
REQ-017 Inputs iaddr/daddr/dstore changing after grant SHALL have no effect on the active transaction.

Reset
REQ-018 nRST=0 SHALL immediately force: state IDLE; ramREN=ramWEN=0; ramaddr=ramstore=0; iwait=dwait=1; iload=dload=0; ramerr=0; streak and retry counts 0.
REQ-019 Reset mid-transaction SHALL drop the RAM request asynchronously with no completion pulse; after release, arbitration restarts from IDLE.

Verification
REQ-020 Bench SHALL cover:
- iREN=1, iaddr=0x40, ramstate ACCESS on 2nd serve cycle, ramload=0x8C220000 -> ramREN=1 from cycle N+1; one-cycle iwait=0 with iload=0x8C220000.
- dWEN=dREN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait=0 on ACCESS.
- iREN and dREN held high continuously, each serve reaching ACCESS after 1 cycle -> grant order D,D,I,D,D,I.
- ramstate ERROR twice, then ACCESS -> two RETRY cycles with enables 0; completion with real ramload; ramerr=0.
- ramstate ERROR 4 times -> dload=0xBAD1BAD1 with dwait=0; ramerr=1 until nRST.
- nRST low during SERVE_D with BUSY -> ramWEN=0 in the same cycle; no dwait=0 pulse; clean transaction after release.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: arbitrates instruction and data requests onto a single RAM port.
// Data wins by default, but after DSTREAK back-to-back data grants with an
// instruction fetch waiting, the fetch is served next. RAM ERROR responses are
// retried after a one-cycle back-off; once the retry budget is spent the
// transaction completes with a poison word and a sticky error flag.
module ram_arbiter #(
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned DSTREAK   = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    // instruction port
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    // data port
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    // RAM side
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        ramerr
);

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RETRY} state_t;

    // wide enough to hold MAX_RETRY without wrapping
    localparam int unsigned RW         = $clog2(MAX_RETRY + 2);
    localparam logic [1:0]  STREAK_MAX = 2'(DSTREAK);
    localparam logic [31:0] BAD_WORD   = 32'hBAD1BAD1;

    state_t        state;
    ramstate_t     rs;
    logic [RW-1:0] retry_cnt;
    logic [1:0]    streak;
    logic          lat_d;
    logic          lat_wr;

    logic          serving;
    logic          exhausted;
    logic          done_ok;
    logic          done_bad;
    logic          req_d;
    logic          grant_d;
    logic          grant_i;

    assign rs        = ramstate_t'(ramstate);
    assign serving   = (state == SERVE_I) || (state == SERVE_D);
    assign exhausted = (retry_cnt >= RW'(MAX_RETRY));
    assign done_ok   = serving && (rs == ACCESS);
    assign done_bad  = serving && (rs == ERROR) && exhausted;

    assign req_d   = dREN | dWEN;
    assign grant_d = req_d && !((streak == STREAK_MAX) && iREN);
    assign grant_i = iREN && !grant_d;

    // completion handshake: wait drops and load is presented in the finishing cycle
    always_comb begin
        iwait = 1'b1;
        dwait = 1'b1;
        iload = '0;
        dload = '0;
        if (state == SERVE_I && (done_ok || done_bad)) begin
            iwait = 1'b0;
            iload = done_bad ? BAD_WORD : ramload;
        end
        if (state == SERVE_D && (done_ok || done_bad)) begin
            dwait = 1'b0;
            if (done_bad)
                dload = BAD_WORD;
            else if (!lat_wr)
                dload = ramload;
        end
    end

    // arbitration FSM; RAM-side outputs are registered from the latched request
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            ramREN    <= 1'b0;
            ramWEN    <= 1'b0;
            ramaddr   <= '0;
            ramstore  <= '0;
            ramerr    <= 1'b0;
            retry_cnt <= '0;
            streak    <= '0;
            lat_d     <= 1'b0;
            lat_wr    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_d || grant_i) begin
                        state     <= grant_d ? SERVE_D : SERVE_I;
                        ramaddr   <= grant_d ? daddr : iaddr;
                        ramstore  <= grant_d ? dstore : '0;
                        lat_d     <= grant_d;
                        lat_wr    <= grant_d && dWEN;
                        ramWEN    <= grant_d && dWEN;
                        ramREN    <= !(grant_d && dWEN);
                        retry_cnt <= '0;
                        if (grant_d && iREN)
                            streak <= (streak == STREAK_MAX) ? streak : streak + 2'd1;
                        else
                            streak <= '0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    case (rs)
                        ACCESS: begin
                            state    <= IDLE;
                            ramREN   <= 1'b0;
                            ramWEN   <= 1'b0;
                            ramaddr  <= '0;
                            ramstore <= '0;
                        end
                        ERROR: begin
                            if (exhausted) begin
                                state    <= IDLE;
                                ramerr   <= 1'b1;
                                ramREN   <= 1'b0;
                                ramWEN   <= 1'b0;
                                ramaddr  <= '0;
                                ramstore <= '0;
                            end else begin
                                state     <= RETRY;
                                retry_cnt <= retry_cnt + RW'(1);
                                ramREN    <= 1'b0;
                                ramWEN    <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
                RETRY: begin
                    state  <= lat_d ? SERVE_D : SERVE_I;
                    ramREN <= !lat_wr;
                    ramWEN <= lat_wr;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
